// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit adder slice.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, ADD, HOLD} nsa_state_t;

    localparam int NIBBLE = 4;

endpackage

// File: rtl/full_adder_4_bit.sv
// 4-bit ripple-carry adder slice: one nibble of a, b plus carry-in per use.
module full_adder_4_bit
    import adder_pkg::*;
(
    input  logic [NIBBLE-1:0] i_a,
    input  logic [NIBBLE-1:0] i_b,
    input  logic              i_cin,
    output logic [NIBBLE-1:0] o_sum,
    output logic              o_cout
);

    logic [NIBBLE:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < NIBBLE; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared 4-bit adder,
// LSB nibble first, with valid/ready handshakes on both operand and result sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NNIB  = WIDTH / NIBBLE;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

    generate
        if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    nsa_state_t        r_state;
    nsa_state_t        w_state_next;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;

    logic [NIBBLE-1:0] w_fa_sum;
    logic              w_fa_cout;
    logic              w_op_xfer;
    logic              w_res_xfer;
    logic              w_last;
    logic              w_c_msb;

    full_adder_4_bit u_fa4 (
        .i_a    (r_a_sh[NIBBLE-1:0]),
        .i_b    (r_b_sh[NIBBLE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_op_xfer  = in_valid & in_ready;
    assign w_res_xfer = out_valid & out_ready;
    assign w_last     = (r_state == ADD) && (r_cnt == LAST_NIB);
    // Carry into the MSB, recovered from the top bit of the last nibble step.
    assign w_c_msb    = r_a_sh[NIBBLE-1] ^ r_b_sh[NIBBLE-1] ^ w_fa_sum[NIBBLE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_op_xfer) w_state_next = ADD;
            ADD:     if (r_cnt == LAST_NIB) w_state_next = HOLD;
            HOLD:    if (w_res_xfer) w_state_next = in_valid ? ADD : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
        out_valid = (r_state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_op_xfer) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == ADD) begin
            r_a_sh  <= {{NIBBLE{1'b0}}, r_a_sh[WIDTH-1:NIBBLE]};
            r_b_sh  <= {{NIBBLE{1'b0}}, r_b_sh[WIDTH-1:NIBBLE]};
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:NIBBLE]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_fa_cout;
                r_ovf  <= w_c_msb ^ w_fa_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=16 and WIDTH=8 against a plain-arithmetic model.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // Returns {cout, ovf, sum}: signed overflow when both operands share a sign the sum lacks.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        ov;
        t  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        ov = (x[15] == y[15]) && (t[15] != x[15]);
        return {t[16], ov, t[15:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       ov;
        t  = {1'b0, x} + {1'b0, y} + {8'd0, c};
        ov = (x[7] == y[7]) && (t[7] != x[7]);
        return {t[8], ov, t[7:0]};
    endfunction

    task automatic run_vec16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                             input int stall, input string name);
        logic [17:0] exp;
        int          n;
        exp = model16(va, vb, vc);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready);
            in_valid = 1'b0; return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 4) begin
            failures++; $display("FAIL %s latency: got %0d edges expected 4", name, n);
        end
        checks++;
        if ({cout, ovf, sum} !== exp) begin
            failures++; $display("FAIL %s result: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                                 name, cout, ovf, sum, exp[17], exp[16], exp[15:0]);
        end
        repeat (stall) begin @(posedge clk); #1; end
        checks++;
        if ({out_valid, cout, ovf, sum} !== {1'b1, exp}) begin
            failures++; $display("FAIL %s hold: got v=%b sum=%h expected v=1 sum=%h", name, out_valid, sum, exp[15:0]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL %s single_xfer: out_valid=%b expected 0", name, out_valid);
        end
        out_ready = 1'b0;
        $display("txn16 %s a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", name, va, vb, vc, exp[15:0], exp[17], exp[16]);
    endtask

    task automatic run_vec8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                            input int stall, input string name);
        logic [9:0] exp;
        int         n;
        exp = model8(va, vb, vc);
        a8 = va; b8 = vb; cin8 = vc; in_valid8 = 1'b1; out_ready8 = (stall == 0);
        n = 0;
        while (!in_ready8 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready8 !== 1'b1) begin
            failures++; $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready8);
            in_valid8 = 1'b0; return;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        n = 0;
        while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 2) begin
            failures++; $display("FAIL %s latency: got %0d edges expected 2", name, n);
        end
        checks++;
        if ({cout8, ovf8, sum8} !== exp) begin
            failures++; $display("FAIL %s result: got cout=%b ovf=%b sum=%h expected cout=%b ovf=%b sum=%h",
                                 name, cout8, ovf8, sum8, exp[9], exp[8], exp[7:0]);
        end
        repeat (stall) begin @(posedge clk); #1; end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid8 !== 1'b0) begin
            failures++; $display("FAIL %s single_xfer: out_valid=%b expected 0", name, out_valid8);
        end
        out_ready8 = 1'b0;
        $display("txn8 %s a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b", name, va, vb, vc, exp[7:0], exp[9], exp[8]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset16: rdy=%b v=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
                                 in_ready, out_valid, sum, cout, ovf);
        end
        checks++;
        if ({in_ready8, out_valid8, sum8} !== {1'b1, 1'b0, 8'h0}) begin
            failures++; $display("FAIL reset8: rdy=%b v=%b sum=%h expected 1 0 00", in_ready8, out_valid8, sum8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++; $display("FAIL reset_release: rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        run_vec16(16'h1234, 16'h4321, 1'b0, 0, "basic");
        run_vec16(16'hFFFF, 16'h0001, 1'b0, 0, "wrap");
        run_vec16(16'hFFFF, 16'hFFFF, 1'b1, 0, "all_ones_cin");
        run_vec16(16'h7FFF, 16'h0001, 1'b0, 0, "pos_ovf");
        run_vec16(16'h8000, 16'h8000, 1'b0, 0, "neg_ovf");
        run_vec8(8'hFF, 8'hFF, 1'b1, 0, "all_ones_cin8");
        run_vec8(8'h7F, 8'h01, 1'b0, 0, "pos_ovf8");
    endtask

    task automatic test_stall();
        logic [17:0] exp;
        int          n;
        exp = model16(16'h00FF, 16'h0F01, 1'b1);
        a = 16'h00FF; b = 16'h0F01; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom);
            #1;
            checks++;
            if ({in_ready, out_valid, cout, ovf, sum} !== {1'b0, 1'b1, exp}) begin
                failures++; $display("FAIL stall[%0d]: rdy=%b v=%b sum=%h expected rdy=0 v=1 sum=%h",
                                     i, in_ready, out_valid, sum, exp[15:0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL stall_release: v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_single: out_valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
        $display("txn16 stall a=00ff b=0f01 cin=1 -> sum=%h", exp[15:0]);
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa [6];
        logic [15:0] ob [6];
        logic        oc [6];
        int          idx_in, idx_out, last_cyc;
        bit          acc;
        for (int i = 0; i < 6; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom);
        end
        idx_in = 0; idx_out = 0; last_cyc = 0;
        a = oa[0]; b = ob[0]; cin = oc[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && idx_out < 6; cyc++) begin
            if (out_valid) begin
                checks++;
                if ({cout, ovf, sum} !== model16(oa[idx_out], ob[idx_out], oc[idx_out])) begin
                    failures++; $display("FAIL b2b[%0d] result: got sum=%h expected sum=%h",
                                         idx_out, sum, model16(oa[idx_out], ob[idx_out], oc[idx_out]) & 18'hFFFF);
                end
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b[%0d] in_ready: got %b expected 1", idx_out, in_ready);
                end
                if (idx_out > 0) begin
                    checks++;
                    if (cyc - last_cyc != 5) begin
                        failures++; $display("FAIL b2b[%0d] spacing: got %0d expected 5", idx_out, cyc - last_cyc);
                    end
                end
                $display("txn16 b2b[%0d] a=%h b=%h cin=%b sum=%h", idx_out, oa[idx_out], ob[idx_out], oc[idx_out], sum);
                last_cyc = cyc;
                idx_out++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 6) begin
                    a = oa[idx_in]; b = ob[idx_in]; cin = oc[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (idx_out != 6) begin
            failures++; $display("FAIL b2b count: got %0d results expected 6", idx_out);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_add();
        int seen;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0}) begin
            failures++; $display("FAIL reset_mid: v=%b rdy=%b sum=%h expected v=0 rdy=1 sum=0000",
                                 out_valid, in_ready, sum);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL reset_mid no_pulse: out_valid high %0d cycles expected 0", seen);
        end
        out_ready = 1'b0;
        run_vec16(16'h0001, 16'h0001, 1'b0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_vec16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand16");
        end
        for (int i = 0; i < 1000; i++) begin
            run_vec8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand8");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid_add();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
